// File: rtl/parity_accum_mem_if.sv
// Write-request, row-read-request and row-response bundle for the banked parity store.
interface parity_accum_mem_if #(
  parameter int NUM_BANKS  = 4,
  parameter int LOG2_DEPTH = 6,
  parameter int PARITY_W   = 8,
  parameter int ADDR_W     = LOG2_DEPTH
);
  localparam int ROWS  = (2 ** LOG2_DEPTH) / NUM_BANKS;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                          wr_req_val;
  logic [ADDR_W-1:0]             wr_req_addr;
  logic [PARITY_W-1:0]           wr_req_data;
  logic                          wr_req_accum;
  logic                          wr_req_rdy;
  logic                          rd_req_val;
  logic [ROW_W-1:0]              rd_req_row;
  logic                          rd_req_clear;
  logic                          rd_req_rdy;
  logic                          rd_resp_val;
  logic [NUM_BANKS*PARITY_W-1:0] rd_resp_data;
  logic                          rd_resp_rdy;

  modport master (
    output wr_req_val, wr_req_addr, wr_req_data, wr_req_accum,
    output rd_req_val, rd_req_row, rd_req_clear, rd_resp_rdy,
    input  wr_req_rdy, rd_req_rdy, rd_resp_val, rd_resp_data
  );

  modport slave (
    input  wr_req_val, wr_req_addr, wr_req_data, wr_req_accum,
    input  rd_req_val, rd_req_row, rd_req_clear, rd_resp_rdy,
    output wr_req_rdy, rd_req_rdy, rd_resp_val, rd_resp_data
  );
endinterface

// File: rtl/parity_accum_mem.sv
// Banked GF(2^m) parity store: overwrite/XOR-accumulate word writes, whole-row reads
// with optional clear-on-read, self-zeroing after reset.
module parity_accum_mem #(
  parameter int NUM_BANKS  = 4,
  parameter int LOG2_DEPTH = 6,
  parameter int PARITY_W   = 8,
  parameter int ADDR_W     = LOG2_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  parity_accum_mem_if.slave bus
);
  localparam int LOG2_NB    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
  localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int ROWS       = (2 ** LOG2_DEPTH) / NUM_BANKS;
  localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int ROW_DATA_W = NUM_BANKS * PARITY_W;

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  function automatic logic [PARITY_W-1:0] gf_add(input logic [PARITY_W-1:0] a,
                                                 input logic [PARITY_W-1:0] b);
    return a ^ b;
  endfunction

  state_t                state_r;
  logic [ROW_W-1:0]      init_row_r;
  logic                  s1_val_r;
  logic                  s1_accum_r;
  logic [BANK_W-1:0]     s1_bank_r;
  logic [ROW_W-1:0]      s1_row_r;
  logic [PARITY_W-1:0]   s1_data_r;
  logic [PARITY_W-1:0]   s1_rdata_r;
  logic                  clr_val_r;
  logic [ROW_W-1:0]      clr_row_r;
  logic [PARITY_W-1:0]   mem_r [NUM_BANKS][ROWS];
  logic [ROW_DATA_W-1:0] fifo_r [2];
  logic                  wptr_r;
  logic                  rptr_r;
  logic [1:0]            count_r;

  logic [BANK_W-1:0]     wr_bank_s;
  logic [ROW_W-1:0]      wr_row_s;
  logic                  rd_rdy_s;
  logic                  rd_acc_s;
  logic                  wr_rdy_s;
  logic                  wr_acc_s;
  logic                  pop_s;
  logic [ROW_W-1:0]      raddr_s;
  logic [ROW_W-1:0]      waddr_s;
  logic [PARITY_W-1:0]   wdata_s;
  logic [NUM_BANKS-1:0]  wen_s;
  logic [PARITY_W-1:0]   s1_new_s;
  logic [PARITY_W-1:0]   rd_word_s [NUM_BANKS];
  logic [ROW_DATA_W-1:0] row_data_s;

  assign wr_bank_s = BANK_W'(bus.wr_req_addr & ADDR_W'(NUM_BANKS - 1));
  assign wr_row_s  = ROW_W'(bus.wr_req_addr >> LOG2_NB);

  // A read owns the shared RAM read port and a clearing read owns the next write slot.
  assign rd_rdy_s = (state_r == ST_RUN) && (count_r < 2'd2);
  assign rd_acc_s = bus.rd_req_val && rd_rdy_s;
  assign wr_rdy_s = (state_r == ST_RUN) && !(rd_acc_s && (bus.wr_req_accum || bus.rd_req_clear));
  assign wr_acc_s = bus.wr_req_val && wr_rdy_s;
  assign pop_s    = (count_r != 2'd0) && bus.rd_resp_rdy;
  assign raddr_s  = rd_acc_s ? bus.rd_req_row : wr_row_s;
  assign s1_new_s = s1_accum_r ? gf_add(s1_rdata_r, s1_data_r) : s1_data_r;

  assign bus.wr_req_rdy   = wr_rdy_s;
  assign bus.rd_req_rdy   = rd_rdy_s;
  assign bus.rd_resp_val  = (count_r != 2'd0);
  assign bus.rd_resp_data = fifo_r[rptr_r];

  // Write-port owner: init zeroing, then a pending clear, then the S1 write.
  always_comb begin
    waddr_s = s1_row_r;
    wdata_s = s1_new_s;
    wen_s   = '0;
    if (state_r == ST_INIT) begin
      waddr_s = init_row_r;
      wdata_s = '0;
      wen_s   = '1;
    end else if (clr_val_r) begin
      waddr_s = clr_row_r;
      wdata_s = '0;
      wen_s   = '1;
    end else if (s1_val_r) begin
      wen_s[s1_bank_r] = 1'b1;
    end else begin
      wen_s = '0;
    end
  end

  // RAM read with forwarding of the word being written this cycle; bank 0 lands in the MSBs.
  always_comb begin
    row_data_s = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (wen_s[b] && (waddr_s == raddr_s)) begin
        rd_word_s[b] = wdata_s;
      end else begin
        rd_word_s[b] = mem_r[b][raddr_s];
      end
      row_data_s[(NUM_BANKS-b)*PARITY_W-1 -: PARITY_W] = rd_word_s[b];
    end
  end

  // Bank RAM write ports.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (wen_s[b]) begin
        mem_r[b][waddr_s] <= wdata_s;
      end
    end
  end

  // Pipeline payload and response storage; qualified by the reset-controlled valids.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      s1_bank_r  <= wr_bank_s;
      s1_row_r   <= wr_row_s;
      s1_data_r  <= bus.wr_req_data;
      s1_accum_r <= bus.wr_req_accum;
      s1_rdata_r <= rd_word_s[wr_bank_s];
    end
    if (rd_acc_s) begin
      fifo_r[wptr_r] <= row_data_s;
      clr_row_r      <= bus.rd_req_row;
    end
  end

  // Control FSM, pipeline valids and response FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_INIT;
      init_row_r <= '0;
      s1_val_r   <= 1'b0;
      clr_val_r  <= 1'b0;
      count_r    <= 2'd0;
      wptr_r     <= 1'b0;
      rptr_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          if (init_row_r == ROW_W'(ROWS - 1)) begin
            state_r <= ST_RUN;
          end else begin
            init_row_r <= init_row_r + ROW_W'(1);
          end
        end
        ST_RUN:  state_r <= ST_RUN;
        default: state_r <= ST_INIT;
      endcase
      s1_val_r  <= wr_acc_s;
      clr_val_r <= rd_acc_s && bus.rd_req_clear;
      if (rd_acc_s) begin
        wptr_r <= ~wptr_r;
      end
      if (pop_s) begin
        rptr_r <= ~rptr_r;
      end
      case ({rd_acc_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: tb/tb_parity_accum_mem.sv
// Directed bench for parity_accum_mem (4 banks x 16 rows x 8 bits).
module tb_parity_accum_mem;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  parity_accum_mem_if #(.NUM_BANKS(4), .LOG2_DEPTH(6), .PARITY_W(8)) bus ();

  parity_accum_mem #(.NUM_BANKS(4), .LOG2_DEPTH(6), .PARITY_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic idle();
    bus.wr_req_val   = 1'b0;
    bus.wr_req_addr  = '0;
    bus.wr_req_data  = '0;
    bus.wr_req_accum = 1'b0;
    bus.rd_req_val   = 1'b0;
    bus.rd_req_row   = '0;
    bus.rd_req_clear = 1'b0;
    bus.rd_resp_rdy  = 1'b1;
  endtask

  task automatic wait_init(output int lowcnt);
    lowcnt = 0;
    #1;
    while (!bus.rd_req_rdy && lowcnt < 100) begin
      lowcnt++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic write_word(input logic [5:0] addr, input logic [7:0] data,
                            input logic acc, output logic ok);
    int w;
    w = 0;
    bus.wr_req_val   = 1'b1;
    bus.wr_req_addr  = addr;
    bus.wr_req_data  = data;
    bus.wr_req_accum = acc;
    #1;
    while (!bus.wr_req_rdy && w < 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    ok = bus.wr_req_rdy;
    @(negedge clk);
    bus.wr_req_val = 1'b0;
  endtask

  task automatic read_row(input logic [3:0] row, input logic clr,
                          output logic [31:0] data, output int lat, output logic ok);
    int w;
    w    = 0;
    ok   = 1'b0;
    lat  = 0;
    data = '0;
    bus.rd_req_val   = 1'b1;
    bus.rd_req_row   = row;
    bus.rd_req_clear = clr;
    #1;
    while (!bus.rd_req_rdy && w < 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (bus.rd_req_rdy) begin
      @(negedge clk);
      bus.rd_req_val   = 1'b0;
      bus.rd_req_clear = 1'b0;
      lat = 1;
      #1;
      while (!bus.rd_resp_val && lat < 50) begin
        @(negedge clk);
        #1;
        lat++;
      end
      if (bus.rd_resp_val) begin
        data = bus.rd_resp_data;
        ok   = 1'b1;
      end
    end else begin
      bus.rd_req_val = 1'b0;
    end
  endtask

  task automatic test_reset();
    int lowcnt;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.wr_req_rdy !== 1'b0) begin failures++; $display("FAIL reset_wr_rdy: got %b expected 0", bus.wr_req_rdy); end
    checks++;
    if (bus.rd_req_rdy !== 1'b0) begin failures++; $display("FAIL reset_rd_rdy: got %b expected 0", bus.rd_req_rdy); end
    checks++;
    if (bus.rd_resp_val !== 1'b0) begin failures++; $display("FAIL reset_resp_val: got %b expected 0", bus.rd_resp_val); end
    rst = 1'b0;
    wait_init(lowcnt);
    checks++;
    if (lowcnt !== 16) begin failures++; $display("FAIL init_cycles: got %0d expected 16", lowcnt); end
    checks++;
    if (bus.wr_req_rdy !== 1'b1) begin failures++; $display("FAIL init_wr_rdy: got %b expected 1", bus.wr_req_rdy); end
  endtask

  task automatic test_all_zero(input string tag);
    logic [31:0] d;
    int          lat;
    logic        ok;
    @(negedge clk);
    for (int r = 0; r < 16; r++) begin
      read_row(4'(r), 1'b0, d, lat, ok);
      checks++;
      if (!ok || d !== 32'h0000_0000) begin
        failures++;
        $display("FAIL %s_row%0d: got %h ok=%b expected 00000000", tag, r, d, ok);
      end
    end
  endtask

  task automatic test_overwrite();
    logic [31:0] d;
    int          lat;
    logic        ok;
    logic        okall;
    okall = 1'b1;
    @(negedge clk);
    write_word(6'd4, 8'h11, 1'b0, ok); okall &= ok;
    write_word(6'd5, 8'h22, 1'b0, ok); okall &= ok;
    write_word(6'd6, 8'h33, 1'b0, ok); okall &= ok;
    write_word(6'd7, 8'h44, 1'b0, ok); okall &= ok;
    checks++;
    if (okall !== 1'b1) begin failures++; $display("FAIL overwrite_accept: got %b expected 1", okall); end
    read_row(4'd1, 1'b0, d, lat, ok);
    checks++;
    if (d !== 32'h1122_3344) begin failures++; $display("FAIL overwrite_row1: got %h expected 11223344", d); end
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL read_latency: got %0d expected 1", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int          lat;
    logic        ok;
    logic        okall;
    okall = 1'b1;
    @(negedge clk);
    write_word(6'd9, 8'h0F, 1'b1, ok); okall &= ok;
    write_word(6'd9, 8'hF0, 1'b1, ok); okall &= ok;
    write_word(6'd9, 8'h3C, 1'b1, ok); okall &= ok;
    checks++;
    if (okall !== 1'b1) begin failures++; $display("FAIL b2b_accept: got %b expected 1", okall); end
    read_row(4'd2, 1'b0, d, lat, ok);
    checks++;
    if (d !== 32'h00C3_0000) begin failures++; $display("FAIL b2b_row2: got %h expected 00c30000", d); end
  endtask

  task automatic test_clear_on_read();
    logic [31:0] d;
    int          lat;
    logic        ok;
    @(negedge clk);
    bus.rd_req_val   = 1'b1;
    bus.rd_req_row   = 4'd1;
    bus.rd_req_clear = 1'b1;
    bus.wr_req_val   = 1'b1;
    bus.wr_req_addr  = 6'd4;
    bus.wr_req_data  = 8'h01;
    bus.wr_req_accum = 1'b1;
    #1;
    checks++;
    if (bus.rd_req_rdy !== 1'b1) begin failures++; $display("FAIL clr_rd_rdy: got %b expected 1", bus.rd_req_rdy); end
    checks++;
    if (bus.wr_req_rdy !== 1'b0) begin failures++; $display("FAIL clr_wr_blocked: got %b expected 0", bus.wr_req_rdy); end
    @(negedge clk);
    bus.rd_req_val   = 1'b0;
    bus.rd_req_clear = 1'b0;
    #1;
    checks++;
    if (bus.rd_resp_val !== 1'b1 || bus.rd_resp_data !== 32'h1122_3344) begin
      failures++;
      $display("FAIL clr_resp: got val=%b data=%h expected val=1 data=11223344", bus.rd_resp_val, bus.rd_resp_data);
    end
    checks++;
    if (bus.wr_req_rdy !== 1'b1) begin failures++; $display("FAIL clr_wr_next: got %b expected 1", bus.wr_req_rdy); end
    @(negedge clk);
    bus.wr_req_val = 1'b0;
    read_row(4'd1, 1'b0, d, lat, ok);
    checks++;
    if (d !== 32'h0100_0000) begin failures++; $display("FAIL clr_fwd_zero: got %h expected 01000000", d); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] d;
    int          lat;
    logic        ok;
    @(negedge clk);
    bus.rd_req_val   = 1'b1;
    bus.rd_req_row   = 4'd3;
    bus.wr_req_val   = 1'b1;
    bus.wr_req_addr  = 6'd12;
    bus.wr_req_data  = 8'hAA;
    bus.wr_req_accum = 1'b0;
    #1;
    checks++;
    if (bus.wr_req_rdy !== 1'b1) begin failures++; $display("FAIL same_wr_rdy: got %b expected 1", bus.wr_req_rdy); end
    @(negedge clk);
    bus.rd_req_val = 1'b0;
    bus.wr_req_val = 1'b0;
    #1;
    checks++;
    if (bus.rd_resp_val !== 1'b1 || bus.rd_resp_data !== 32'h0000_0000) begin
      failures++;
      $display("FAIL same_invisible: got val=%b data=%h expected val=1 data=00000000", bus.rd_resp_val, bus.rd_resp_data);
    end
    @(negedge clk);
    read_row(4'd3, 1'b0, d, lat, ok);
    checks++;
    if (d !== 32'hAA00_0000) begin failures++; $display("FAIL same_later: got %h expected aa000000", d); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    bus.rd_resp_rdy = 1'b0;
    bus.rd_req_val  = 1'b1;
    bus.rd_req_row  = 4'd2;
    #1;
    checks++;
    if (bus.rd_req_rdy !== 1'b1) begin failures++; $display("FAIL bp_first_rdy: got %b expected 1", bus.rd_req_rdy); end
    @(negedge clk);
    bus.rd_req_row = 4'd1;
    #1;
    checks++;
    if (bus.rd_req_rdy !== 1'b1) begin failures++; $display("FAIL bp_second_rdy: got %b expected 1", bus.rd_req_rdy); end
    @(negedge clk);
    bus.rd_req_row = 4'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.rd_req_rdy !== 1'b0) begin failures++; $display("FAIL bp_full_rdy%0d: got %b expected 0", i, bus.rd_req_rdy); end
      checks++;
      if (bus.rd_resp_val !== 1'b1 || bus.rd_resp_data !== 32'h00C3_0000) begin
        failures++;
        $display("FAIL bp_hold%0d: got val=%b data=%h expected val=1 data=00c30000", i, bus.rd_resp_val, bus.rd_resp_data);
      end
      @(negedge clk);
    end
    bus.rd_resp_rdy = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.rd_resp_data !== 32'h0100_0000) begin failures++; $display("FAIL bp_second_resp: got %h expected 01000000", bus.rd_resp_data); end
    checks++;
    if (bus.rd_req_rdy !== 1'b1) begin failures++; $display("FAIL bp_third_rdy: got %b expected 1", bus.rd_req_rdy); end
    @(negedge clk);
    bus.rd_req_val = 1'b0;
    #1;
    checks++;
    if (bus.rd_resp_val !== 1'b1 || bus.rd_resp_data !== 32'hAA00_0000) begin
      failures++;
      $display("FAIL bp_third_resp: got val=%b data=%h expected val=1 data=aa000000", bus.rd_resp_val, bus.rd_resp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int lowcnt;
    @(negedge clk);
    bus.rd_resp_rdy = 1'b0;
    bus.rd_req_val  = 1'b1;
    bus.rd_req_row  = 4'd1;
    @(negedge clk);
    bus.rd_req_row = 4'd3;
    @(negedge clk);
    bus.rd_req_val = 1'b0;
    #1;
    checks++;
    if (bus.rd_resp_val !== 1'b1) begin failures++; $display("FAIL mid_pending: got %b expected 1", bus.rd_resp_val); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.rd_resp_val !== 1'b0 || bus.rd_req_rdy !== 1'b0 || bus.wr_req_rdy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_outs: got val=%b rd_rdy=%b wr_rdy=%b expected 0 0 0",
               bus.rd_resp_val, bus.rd_req_rdy, bus.wr_req_rdy);
    end
    rst = 1'b0;
    wait_init(lowcnt);
    checks++;
    if (lowcnt !== 16) begin failures++; $display("FAIL mid_init_cycles: got %0d expected 16", lowcnt); end
    bus.rd_resp_rdy = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle();
    test_reset();
    test_all_zero("init");
    test_overwrite();
    test_back_to_back();
    test_clear_on_read();
    test_same_cycle();
    test_backpressure();
    test_reset_mid_run();
    test_all_zero("reinit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/parity_accum_mem.md
# parity_accum_mem

Banked parity store for the Reed-Solomon encoder that generalises the interleaved parity memory. Words are written one at a time, either overwriting or XOR-accumulating into the stored value, which is GF(2^m) addition. Whole rows of NUM_BANKS words are read back with full valid/ready backpressure and optional clear-on-read. After reset the block zeroes its own contents, so encoders can accumulate across messages without a separate clear pass.

## Interface
Parameters:
- NUM_BANKS, 4: bank count; power of two, ≥1.
- LOG2_DEPTH, 6: log2 of total words across all banks.
- PARITY_W, 8: width of one parity word.
- ADDR_W, LOG2_DEPTH: word address width.
- Derived:
  - BANK_W = max(1, log2 NUM_BANKS)
  - ROWS = 2^LOG2_DEPTH / NUM_BANKS
  - ROW_W = max(1, log2 ROWS)

Ports:
- clk, in, 1: clock. Single clock domain.
- rst, in, 1: synchronous, active-high reset.
- wr_req_val, in, 1: write request valid.
- wr_req_addr, in, ADDR_W: word address. Bank = addr mod NUM_BANKS; row = addr >> log2 NUM_BANKS.
- wr_req_data, in, PARITY_W: write data.
- wr_req_accum, in, 1: 1 = stored ^= data; 0 = stored = data.
- wr_req_rdy, out, 1: write accepted when val & rdy.
- rd_req_val, in, 1: row read request valid.
- rd_req_row, in, ROW_W: row index.
- rd_req_clear, in, 1: zero the row after reading it.
- rd_req_rdy, out, 1: read accepted when val & rdy.
- rd_resp_val, out, 1: response valid.
- rd_resp_data, out, NUM_BANKS*PARITY_W: row data. Bank 0 occupies the MSBs; bank b sits at bits [(NUM_BANKS-b)*PARITY_W-1 -: PARITY_W].
- rd_resp_rdy, in, 1: response consumed when val & rdy.

## Operation
- **Storage:** one 1R1W synchronous RAM per bank, ROWS deep.
  - All bank read ports are shared between row reads and the accumulate pre-read.
  - All bank write ports are shared between the write pipeline, clears, and init.
- **FSM states:**
  - INIT is entered on rst. A row counter runs 0..ROWS-1, writing zero to every bank, one row per cycle.
  - In INIT, wr_req_rdy = rd_req_rdy = 0.
  - INIT → RUN after row ROWS-1 is written.
- **Write pipeline, 2 stages:**
  - S0 (accept): for an accumulate, issue the RAM read of (bank, row).
  - S1: compute the new value and write the bank.
  - Overwrites also commit in S1, so ordering is uniform.
- **Forwarding:**
  - If S0 reads a word that S1 writes in the same cycle, S1's result is used in place of the RAM data.
  - If S1 is clearing that row, the forwarded value is zero.
- **Row reads:**
  - Acceptance issues reads on all banks.
  - Data registers into a 2-entry response FIFO one cycle later.
  - Words being written by S1 in the read cycle are forwarded.
- **Clear-on-read:** the row's zero write occupies the write port the cycle after acceptance. That clear is the S1 slot for that cycle.
- **Arbitration in RUN** (rd_req_rdy must not depend on wr_req_val):
  - rd_req_rdy = FIFO has ≥1 free slot, counting the in-flight read.
  - wr_req_rdy = !(rd_req_val & rd_req_rdy & (wr_req_accum | rd_req_clear)).
  - In words: a read wins the shared read port, and a clearing read wins the next write slot.
  - An overwrite alongside a non-clearing read is accepted.
- **Visibility:**
  - A read returns every write accepted in earlier cycles.
  - A write accepted in the same cycle as a read is not visible to that read.
- **Address range:** all addresses are in range by construction; no error path.

## Timing
- **Reset values:**
  - wr_req_rdy = 0, rd_req_rdy = 0, rd_resp_val = 0.
  - FIFO empty, pipeline empty, state INIT.
  - rd_resp_data is don't-care while rd_resp_val = 0.
- **Init:** ready rises exactly ROWS cycles after rst deasserts (first cycle with rst = 0 writes row 0).
- **Read latency:** rd_resp_val rises the cycle after acceptance when the FIFO is empty and the output is idle.
- **Full throughput:** one read per cycle while rd_resp_rdy = 1.
- **Backpressure:**
  - With rd_resp_rdy = 0, a response is held stable until consumed.
  - At most 2 responses are buffered; rd_req_rdy drops when the FIFO plus the in-flight read reaches 2.
- **Write throughput:** one write per cycle, including back-to-back accumulates to the same address via forwarding.
- **rst mid-operation:** pipeline and FIFO are flushed, outputs return to reset values, and INIT re-zeroes the whole memory.

## Test plan
Configuration for all cases: NUM_BANKS=4, LOG2_DEPTH=6, PARITY_W=8.
- **Init:** deassert rst → rdy low for exactly 16 cycles, then high. Read rows 0..15 → every response 0x00000000.
- **Overwrite and bank order:** overwrite addrs 4,5,6,7 with 0x11,0x22,0x33,0x44, then read row 1 → 0x11223344 one cycle after acceptance.
- **Back-to-back accumulate:** accumulate 0x0F, 0xF0, 0x3C to addr 9 on consecutive cycles, then read row 2 → 0x00C30000.
- **Clear-on-read:**
  - Read row 1 with clear → 0x11223344; wr_req_rdy is 0 during the acceptance cycle if an accumulate is presented.
  - Accumulate 0x01 to addr 4 in the following cycle, then read row 1 → 0x01000000 (forwarded zero).
- **Backpressure:** hold rd_resp_rdy=0 and issue 3 reads → only 2 accepted, first response held stable. Release → responses arrive in order and the third read is accepted.
- **Reset mid-run:** assert rst while 2 responses are pending → rd_resp_val=0 next cycle, 16-cycle INIT, rows read back all zero.
